// File: rtl/dram_request_scheduler.sv
// dram_request_scheduler: split read/write request queues with a watermark write-drain
// policy, read-after-write ordering, in-order outstanding tracking and completion callbacks.
// Optional build macro SCHED_PERF_EN adds saturating issue and mode-switch counters.
module dram_request_scheduler #(
    parameter int WORD_W   = 32,
    parameter int RQ_DEPTH = 8,
    parameter int WQ_DEPTH = 8,
    parameter int WQ_HI    = 6,
    parameter int WQ_LO    = 2,
    parameter int MAX_OUT  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] memaddr,
    input  logic [WORD_W-1:0] memstore,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr_rq,
    output logic [WORD_W-1:0] ramstore_rq,
    input  logic              ram_ready,
    output logic [WORD_W-1:0] ramaddr_rq_ft,
    output logic [WORD_W-1:0] ramstore_rq_ft,
    output logic              ft_valid,
    input  logic              request_done,
    output logic [WORD_W-1:0] memaddr_callback,
    output logic              callback_valid,
    output logic              callback_wr,
    output logic              err
`ifdef SCHED_PERF_EN
    ,
    output logic [31:0]       perf_rd_issued,
    output logic [31:0]       perf_wr_issued,
    output logic [31:0]       perf_mode_sw
`endif
);
    localparam int RQ_AW = $clog2(RQ_DEPTH);
    localparam int RQ_CW = RQ_AW + 1;
    localparam int WQ_AW = $clog2(WQ_DEPTH);
    localparam int WQ_CW = WQ_AW + 1;
    localparam int OT_AW = $clog2(MAX_OUT);
    localparam int OT_CW = OT_AW + 1;

    typedef enum logic {READ_MODE, WRITE_DRAIN} mode_e;

    logic [WORD_W-1:0] rq_mem_q [RQ_DEPTH];
    logic [WORD_W-1:0] rq_mem_d [RQ_DEPTH];
    logic [RQ_AW-1:0]  rq_rp_q, rq_rp_d, rq_wp_q, rq_wp_d, rq_rp_nx;
    logic [RQ_CW-1:0]  rq_cnt_q, rq_cnt_d;

    logic [WORD_W-1:0] wq_addr_q [WQ_DEPTH];
    logic [WORD_W-1:0] wq_addr_d [WQ_DEPTH];
    logic [WORD_W-1:0] wq_data_q [WQ_DEPTH];
    logic [WORD_W-1:0] wq_data_d [WQ_DEPTH];
    logic [WQ_AW-1:0]  wq_rp_q, wq_rp_d, wq_wp_q, wq_wp_d, wq_rp_nx;
    logic [WQ_CW-1:0]  wq_cnt_q, wq_cnt_d;
    logic [WQ_AW-1:0]  wq_off [WQ_DEPTH];

    logic [WORD_W-1:0] ot_addr_q [MAX_OUT];
    logic [WORD_W-1:0] ot_addr_d [MAX_OUT];
    logic              ot_wr_q [MAX_OUT];
    logic              ot_wr_d [MAX_OUT];
    logic [OT_AW-1:0]  ot_rp_q, ot_rp_d, ot_wp_q, ot_wp_d;
    logic [OT_CW-1:0]  ot_cnt_q, ot_cnt_d;

    mode_e             mode_q, mode_d;
    logic              hold_q, hold_d, hold_wr_q, hold_wr_d;
    logic              cb_valid_q, cb_valid_d, cb_wr_q, cb_wr_d, err_q, err_d;
    logic [WORD_W-1:0] cb_addr_q, cb_addr_d;

    logic raw_hit, sel_wr, can_out, rd_ok, wr_ok, issue;
    logic rq_full, wq_full, rq_push, wq_push, rq_pop, wq_pop, ot_pop;

    always_comb begin
        rq_rp_nx = rq_rp_q + RQ_AW'(1);
        wq_rp_nx = wq_rp_q + WQ_AW'(1);
        rq_full  = (rq_cnt_q == RQ_CW'(RQ_DEPTH));
        wq_full  = (wq_cnt_q == WQ_CW'(WQ_DEPTH));
        dwait    = dWEN ? wq_full : (dREN & rq_full);
        wq_push  = dWEN & ~wq_full;
        rq_push  = dREN & ~dWEN & ~rq_full;

        // RAW hazard: read-queue head matches any live write-queue entry
        raw_hit = 1'b0;
        for (int i = 0; i < WQ_DEPTH; i++) begin
            wq_off[i] = WQ_AW'(i) - wq_rp_q;
            if ((rq_cnt_q != '0) && ({1'b0, wq_off[i]} < wq_cnt_q) &&
                (wq_addr_q[i] == rq_mem_q[rq_rp_q]))
                raw_hit = 1'b1;
        end

        // A presented-but-unaccepted request keeps its queue selected until taken
        sel_wr  = hold_q ? hold_wr_q : (mode_q == WRITE_DRAIN);
        can_out = (ot_cnt_q < OT_CW'(MAX_OUT));
        rd_ok   = ~sel_wr & (rq_cnt_q != '0) & can_out & (hold_q | ~raw_hit);
        wr_ok   = sel_wr & (wq_cnt_q != '0) & can_out;
        issue   = (rd_ok | wr_ok) & ram_ready;
        rq_pop  = issue & rd_ok;
        wq_pop  = issue & wr_ok;
        ot_pop  = request_done & (ot_cnt_q != '0);

        ramREN      = rd_ok;
        ramWEN      = wr_ok;
        ramaddr_rq  = rd_ok ? rq_mem_q[rq_rp_q] : (wr_ok ? wq_addr_q[wq_rp_q] : '0);
        ramstore_rq = wr_ok ? wq_data_q[wq_rp_q] : '0;

        ft_valid       = sel_wr ? (wq_cnt_q >= WQ_CW'(2)) : (rq_cnt_q >= RQ_CW'(2));
        ramaddr_rq_ft  = '0;
        ramstore_rq_ft = '0;
        if (ft_valid) begin
            ramaddr_rq_ft  = sel_wr ? wq_addr_q[wq_rp_nx] : rq_mem_q[rq_rp_nx];
            ramstore_rq_ft = sel_wr ? wq_data_q[wq_rp_nx] : '0;
        end
    end

    always_comb begin
        rq_mem_d = rq_mem_q;
        rq_wp_d  = rq_wp_q;
        rq_rp_d  = rq_rp_q;
        if (rq_push) begin
            rq_mem_d[rq_wp_q] = memaddr;
            rq_wp_d           = rq_wp_q + RQ_AW'(1);
        end
        if (rq_pop) rq_rp_d = rq_rp_nx;
        rq_cnt_d = rq_cnt_q + RQ_CW'(rq_push) - RQ_CW'(rq_pop);

        wq_addr_d = wq_addr_q;
        wq_data_d = wq_data_q;
        wq_wp_d   = wq_wp_q;
        wq_rp_d   = wq_rp_q;
        if (wq_push) begin
            wq_addr_d[wq_wp_q] = memaddr;
            wq_data_d[wq_wp_q] = memstore;
            wq_wp_d            = wq_wp_q + WQ_AW'(1);
        end
        if (wq_pop) wq_rp_d = wq_rp_nx;
        wq_cnt_d = wq_cnt_q + WQ_CW'(wq_push) - WQ_CW'(wq_pop);

        ot_addr_d = ot_addr_q;
        ot_wr_d   = ot_wr_q;
        ot_wp_d   = ot_wp_q;
        ot_rp_d   = ot_rp_q;
        if (issue) begin
            ot_addr_d[ot_wp_q] = ramaddr_rq;
            ot_wr_d[ot_wp_q]   = ramWEN;
            ot_wp_d            = ot_wp_q + OT_AW'(1);
        end
        if (ot_pop) ot_rp_d = ot_rp_q + OT_AW'(1);
        ot_cnt_d = ot_cnt_q + OT_CW'(issue) - OT_CW'(ot_pop);

        cb_valid_d = ot_pop;
        cb_addr_d  = ot_pop ? ot_addr_q[ot_rp_q] : '0;
        cb_wr_d    = ot_pop & ot_wr_q[ot_rp_q];
        err_d      = err_q | (request_done & (ot_cnt_q == '0));

        hold_d    = (rd_ok | wr_ok) & ~ram_ready;
        hold_wr_d = wr_ok & ~ram_ready;

        mode_d = mode_q;
        case (mode_q)
            READ_MODE:
                if ((wq_cnt_q >= WQ_CW'(WQ_HI)) || ((rq_cnt_q == '0) && (wq_cnt_q != '0)) || raw_hit)
                    mode_d = WRITE_DRAIN;
            WRITE_DRAIN:
                if ((wq_cnt_q == '0) || ((wq_cnt_q <= WQ_CW'(WQ_LO)) && !raw_hit))
                    mode_d = READ_MODE;
            default: mode_d = READ_MODE;
        endcase
    end

    always_ff @(posedge CLK) begin
        rq_mem_q  <= rq_mem_d;
        wq_addr_q <= wq_addr_d;
        wq_data_q <= wq_data_d;
        ot_addr_q <= ot_addr_d;
        ot_wr_q   <= ot_wr_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rq_rp_q    <= '0;
            rq_wp_q    <= '0;
            rq_cnt_q   <= '0;
            wq_rp_q    <= '0;
            wq_wp_q    <= '0;
            wq_cnt_q   <= '0;
            ot_rp_q    <= '0;
            ot_wp_q    <= '0;
            ot_cnt_q   <= '0;
            mode_q     <= READ_MODE;
            hold_q     <= 1'b0;
            hold_wr_q  <= 1'b0;
            cb_valid_q <= 1'b0;
            cb_wr_q    <= 1'b0;
            cb_addr_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            rq_rp_q    <= rq_rp_d;
            rq_wp_q    <= rq_wp_d;
            rq_cnt_q   <= rq_cnt_d;
            wq_rp_q    <= wq_rp_d;
            wq_wp_q    <= wq_wp_d;
            wq_cnt_q   <= wq_cnt_d;
            ot_rp_q    <= ot_rp_d;
            ot_wp_q    <= ot_wp_d;
            ot_cnt_q   <= ot_cnt_d;
            mode_q     <= mode_d;
            hold_q     <= hold_d;
            hold_wr_q  <= hold_wr_d;
            cb_valid_q <= cb_valid_d;
            cb_wr_q    <= cb_wr_d;
            cb_addr_q  <= cb_addr_d;
            err_q      <= err_d;
        end
    end

    assign callback_valid   = cb_valid_q;
    assign callback_wr      = cb_wr_q;
    assign memaddr_callback = cb_addr_q;
    assign err              = err_q;

`ifdef SCHED_PERF_EN
    logic [31:0] perf_rd_q, perf_rd_d, perf_wr_q, perf_wr_d, perf_sw_q, perf_sw_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

    always_comb begin
        perf_rd_d = sat_inc(perf_rd_q, rq_pop);
        perf_wr_d = sat_inc(perf_wr_q, wq_pop);
        perf_sw_d = sat_inc(perf_sw_q, mode_d != mode_q);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_rd_q <= '0;
            perf_wr_q <= '0;
            perf_sw_q <= '0;
        end else begin
            perf_rd_q <= perf_rd_d;
            perf_wr_q <= perf_wr_d;
            perf_sw_q <= perf_sw_d;
        end
    end

    assign perf_rd_issued = perf_rd_q;
    assign perf_wr_issued = perf_wr_q;
    assign perf_mode_sw   = perf_sw_q;
`endif
endmodule

// File: tb/tb_dram_request_scheduler.sv
// tb_dram_request_scheduler: directed stimulus; a monitor checks every issue handshake
// and every completion callback, in order, against expectations queued by the stimulus.
`timescale 1ns/1ps
module tb_dram_request_scheduler;
    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         dREN = 1'b0, dWEN = 1'b0, ram_ready = 1'b0, request_done = 1'b0;
    logic [W-1:0] memaddr = '0, memstore = '0;
    logic         dwait, ramREN, ramWEN, ft_valid, callback_valid, callback_wr, err;
    logic [W-1:0] ramaddr_rq, ramstore_rq, ramaddr_rq_ft, ramstore_rq_ft, memaddr_callback;
`ifdef SCHED_PERF_EN
    logic [31:0]  perf_rd_issued, perf_wr_issued, perf_mode_sw;
`endif

    dram_request_scheduler dut (
        .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN), .memaddr(memaddr), .memstore(memstore),
        .dwait(dwait), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr_rq(ramaddr_rq),
        .ramstore_rq(ramstore_rq), .ram_ready(ram_ready), .ramaddr_rq_ft(ramaddr_rq_ft),
        .ramstore_rq_ft(ramstore_rq_ft), .ft_valid(ft_valid), .request_done(request_done),
        .memaddr_callback(memaddr_callback), .callback_valid(callback_valid),
        .callback_wr(callback_wr), .err(err)
`ifdef SCHED_PERF_EN
        , .perf_rd_issued(perf_rd_issued), .perf_wr_issued(perf_wr_issued),
        .perf_mode_sw(perf_mode_sw)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed { logic wr; logic [W-1:0] addr; logic [W-1:0] data; } iss_t;
    typedef struct packed { logic wr; logic [W-1:0] addr; } cb_t;
    iss_t exp_iss[$];
    cb_t  exp_cb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic iss_t mk_iss(input logic wr, input logic [W-1:0] a, input logic [W-1:0] d);
        iss_t r;
        r.wr = wr; r.addr = a; r.data = d;
        return r;
    endfunction

    function automatic cb_t mk_cb(input logic wr, input logic [W-1:0] a);
        cb_t r;
        r.wr = wr; r.addr = a;
        return r;
    endfunction

    // Scoreboard monitor: sampled mid-cycle, away from the active edge
    always @(negedge CLK) begin
        if (!RST) begin
            if ((ramREN || ramWEN) && ram_ready) begin
                if (exp_iss.size() == 0)
                    chk("issue_unexpected", {ramWEN, ramaddr_rq, ramstore_rq}, 96'h0);
                else
                    chk("issue_order", {ramWEN, ramaddr_rq, ramstore_rq}, exp_iss.pop_front());
            end
            if (callback_valid) begin
                if (exp_cb.size() == 0)
                    chk("callback_unexpected", {callback_wr, memaddr_callback}, 96'h0);
                else
                    chk("callback_order", {callback_wr, memaddr_callback}, exp_cb.pop_front());
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        chk("iss_drained", exp_iss.size(), 0);
        chk("cb_drained", exp_cb.size(), 0);
        RST = 1'b1;
        dREN = 1'b0; dWEN = 1'b0; memaddr = '0; memstore = '0;
        ram_ready = 1'b0; request_done = 1'b0;
        step(2);
        chk("rst_flags", {ramREN, ramWEN, dwait, ft_valid, callback_valid, callback_wr, err}, 0);
        chk("rst_data", {ramaddr_rq, ramstore_rq, memaddr_callback}, 0);
        RST = 1'b0;
        step(1);
    endtask

    task automatic wr_req(input logic [W-1:0] a, input logic [W-1:0] d);
        dWEN = 1'b1; memaddr = a; memstore = d;
        step();
        dWEN = 1'b0;
    endtask

    task automatic rd_req(input logic [W-1:0] a);
        dREN = 1'b1; memaddr = a;
        step();
        dREN = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        // Read flow
        do_reset();
        exp_iss.push_back(mk_iss(1'b0, 32'h100, 32'h0));
        ram_ready = 1'b1;
        rd_req(32'h100);
        #1;
        chk("t1_ren_latency", {ramREN, ramaddr_rq}, {1'b1, 32'h100});
        step(3);
        exp_cb.push_back(mk_cb(1'b0, 32'h100));
        request_done = 1'b1;
        step();
        request_done = 1'b0;
        #1;
        chk("t1_cb_pulse", {callback_valid, callback_wr, memaddr_callback}, {1'b1, 1'b0, 32'h100});
        step();
        chk("t1_cb_one_cycle", callback_valid, 0);

        // Write watermark drain
        do_reset();
        for (int i = 0; i < 6; i++) wr_req(32'(32'h200 + 4 * i), 32'(32'hD0 + i));
        rd_req(32'h500);
        rd_req(32'h504);
        step(2);
        chk("t2_hold_write", {ramREN, ramWEN, ramaddr_rq, ramstore_rq}, {1'b0, 1'b1, 32'h200, 32'hD0});
        chk("t2_lookahead", {ft_valid, ramaddr_rq_ft, ramstore_rq_ft}, {1'b1, 32'h204, 32'hD1});
        for (int i = 0; i < 4; i++) exp_iss.push_back(mk_iss(1'b1, 32'(32'h200 + 4 * i), 32'(32'hD0 + i)));
        exp_iss.push_back(mk_iss(1'b0, 32'h500, 32'h0));
        ram_ready = 1'b1;
        step(6);
        chk("t2_out_limit", {ramREN, ramWEN}, 0);
        exp_cb.push_back(mk_cb(1'b1, 32'h200));
        request_done = 1'b1;
        step();
        request_done = 1'b0;
        step(3);
        chk("t2_limit_again", {ramREN, ramWEN}, 0);

        // RAW hazard ordering
        do_reset();
        wr_req(32'h300, 32'hAA);
        rd_req(32'h300);
        step(2);
        chk("t3_write_first", {ramWEN, ramREN, ramaddr_rq}, {1'b1, 1'b0, 32'h300});
        exp_iss.push_back(mk_iss(1'b1, 32'h300, 32'hAA));
        exp_iss.push_back(mk_iss(1'b0, 32'h300, 32'h0));
        ram_ready = 1'b1;
        step(4);
        chk("t3_idle", {ramREN, ramWEN}, 0);

        // Backpressure and lookahead
        do_reset();
        for (int i = 0; i < 8; i++) rd_req(32'(32'h600 + 4 * i));
        dREN = 1'b1; memaddr = 32'h700;
        #1;
        chk("t4_dwait_full", dwait, 1);
        step();
        dREN = 1'b0;
        #1;
        chk("t4_head", {ramREN, ramaddr_rq}, {1'b1, 32'h600});
        chk("t4_lookahead", {ft_valid, ramaddr_rq_ft, ramstore_rq_ft}, {1'b1, 32'h604, 32'h0});
        for (int i = 0; i < 8; i++) exp_iss.push_back(mk_iss(1'b0, 32'(32'h600 + 4 * i), 32'h0));
        for (int i = 0; i < 5; i++) exp_cb.push_back(mk_cb(1'b0, 32'(32'h600 + 4 * i)));
        ram_ready = 1'b1;
        step(5);
        request_done = 1'b1;
        step(5);
        request_done = 1'b0;
        step(8);
        chk("t4_ninth_dropped", {ramREN, ramWEN, ft_valid}, 0);

        // Outstanding limit and err
        do_reset();
        ram_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_iss.push_back(mk_iss(1'b0, 32'(32'h800 + 4 * i), 32'h0));
        for (int i = 0; i < 5; i++) rd_req(32'(32'h800 + 4 * i));
        step(3);
        chk("t5_fifth_held", ramREN, 0);
        exp_iss.push_back(mk_iss(1'b0, 32'h810, 32'h0));
        exp_cb.push_back(mk_cb(1'b0, 32'h800));
        request_done = 1'b1;
        step();
        request_done = 1'b0;
        #1;
        chk("t5_fifth_issue", {ramREN, ramaddr_rq}, {1'b1, 32'h810});
        step(2);
        for (int i = 1; i < 5; i++) exp_cb.push_back(mk_cb(1'b0, 32'(32'h800 + 4 * i)));
        request_done = 1'b1;
        step(5);
        request_done = 1'b0;
        #1;
        chk("t5_err_set", err, 1);
        step(3);
        chk("t5_err_sticky", {err, callback_valid}, {1'b1, 1'b0});

        // Asynchronous reset mid-issue
        do_reset();
        wr_req(32'h900, 32'h55);
        step(2);
        chk("t6_pre_wen", {ramWEN, ramaddr_rq}, {1'b1, 32'h900});
        #2;
        RST = 1'b1;
        #1;
        chk("t6_async_out", {ramREN, ramWEN, ramaddr_rq, ramstore_rq, ft_valid}, 0);
        step();
        RST = 1'b0;
        step();
        chk("t6_post_idle", {ramREN, ramWEN, ft_valid, err, callback_valid}, 0);
        dWEN = 1'b1; memaddr = 32'h904;
        #1;
        chk("t6_dwait_low", dwait, 0);
        step();
        dWEN = 1'b0;

        chk("end_iss_drained", exp_iss.size(), 0);
        chk("end_cb_drained", exp_cb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dram_request_scheduler.md
Name: dram_request_scheduler

Overview:
- Front-end scheduler between the cache/requester side and the DRAM command scheduler.
- Buffers incoming read and write requests in separate queues. Picks between them with a watermark-based read/write drain policy and enforces read-after-write ordering.
- Issues one request at a time over a valid/ready handshake and tracks outstanding requests in order. Returns each completion address as a callback.

Parameters:
- WORD_W, 32, address/data width.
- RQ_DEPTH, 8, read queue entries (power of 2).
- WQ_DEPTH, 8, write queue entries (power of 2).
- WQ_HI, 6, write-queue occupancy that forces WRITE_DRAIN.
- WQ_LO, 2, write-queue occupancy at which WRITE_DRAIN exits.
- MAX_OUT, 4, maximum issued-but-not-done requests (power of 2).

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- dREN  in  1  read request.
- dWEN  in  1  write request.
- memaddr  in  WORD_W  request address.
- memstore  in  WORD_W  write data.
- dwait  out  1  target queue full; request not accepted this cycle.
- ramREN  out  1  issuing read.
- ramWEN  out  1  issuing write.
- ramaddr_rq  out  WORD_W  issued address.
- ramstore_rq  out  WORD_W  issued write data (0 for reads).
- ram_ready  in  1  DRAM scheduler accepts issued request.
- ramaddr_rq_ft  out  WORD_W  next entry behind head of selected queue (lookahead).
- ramstore_rq_ft  out  WORD_W  lookahead write data (0 in read mode).
- ft_valid  out  1  lookahead entry exists.
- request_done  in  1  oldest outstanding request completed.
- memaddr_callback  out  WORD_W  address of completed request.
- callback_valid  out  1  one-cycle completion pulse.
- callback_wr  out  1  completed request was a write.
- err  out  1  sticky: request_done with nothing outstanding.

Behaviour:
- Reset (async, any time including mid-transfer):
  - All queues and the outstanding FIFO are flushed; mode is READ_MODE.
  - Every output is 0, err is cleared, and in-flight requests are dropped.
- Accept:
  - dWEN high: the request targets WQ; otherwise dREN targets RQ.
  - dREN and dWEN both high: treated as a write only.
  - dwait is combinational: high when the targeted queue is full. Acceptance = request high and dwait low.
  - Enqueue is visible for issue the next cycle (latency 1 from accept to earliest ramREN/ramWEN).
- Mode FSM: READ_MODE <-> WRITE_DRAIN.
  - READ_MODE -> WRITE_DRAIN when wq_count >= WQ_HI, or (RQ empty and WQ non-empty), or the RQ head address matches any valid WQ entry (RAW hazard).
  - WRITE_DRAIN -> READ_MODE when WQ empty, or (wq_count <= WQ_LO and no RAW hazard on the RQ head).
  - Mode is evaluated on registered counts; a transition takes effect the next cycle.
- Issue:
  - Head of the selected queue is presented when out_count < MAX_OUT.
  - ramREN/ramWEN, ramaddr_rq and ramstore_rq are held stable until ram_ready.
  - On ram_ready with an active strobe: pop the queue and push {addr, is_write} to the outstanding FIFO.
  - Strobes may be re-asserted the next cycle (back-to-back issue, one per cycle max).
  - A read is never issued while its address is pending in WQ.
- Lookahead: ft outputs show the head+1 entry of the selected queue; ft_valid = count >= 2.
- Completion:
  - request_done pops the outstanding FIFO.
  - callback_valid pulses for exactly one cycle the following cycle, with memaddr_callback and callback_wr registered.
  - request_done with outstanding empty sets err, does not pulse, and leaves state unchanged.
- Simultaneous events:
  - Enqueue and issue-pop on the same queue in one cycle: count unchanged.
  - Issue push and request_done pop in one cycle: out_count unchanged.
  - Full queue with same-cycle pop: dwait still high; no bypass.

Optional Feature:
- Macro: SCHED_PERF_EN.
- Defined: adds 32-bit outputs perf_rd_issued, perf_wr_issued and perf_mode_sw, all reset to 0.
  - They increment on each issued read, issued write and mode transition.
  - They saturate at all-ones.
- Undefined: counters and ports are absent; behaviour is otherwise identical.

Test Plan:
- Read flow: reset; dREN addr 0x100 with ram_ready=1 -> ramREN with ramaddr_rq=0x100 the next cycle. request_done 3 cycles later -> callback_valid=1, memaddr_callback=0x100, callback_wr=0 for one cycle.
- Write watermark: ram_ready=0; accept 6 writes 0x200..0x214 plus 2 reads -> mode enters WRITE_DRAIN. With ram_ready=1, 4 writes issue first (wq_count reaches 2), then reads issue.
- RAW hazard: write 0x300, then read 0x300 in READ_MODE with WQ below WQ_HI -> write 0x300 issues before read 0x300, with no ramREN on 0x300 earlier.
- Backpressure: fill RQ with 8 reads while ram_ready=0 -> dwait=1 on the 9th dREN and the entry is dropped. The ft outputs show the second entry with ft_valid=1.
- Outstanding limit: issue 4 reads with no request_done -> 5th read held with ramREN=0. One request_done -> 5th issues the next cycle. request_done with empty FIFO -> err=1 sticky.
- Async reset mid-issue: RST asserted while ramWEN=1 -> all outputs 0 immediately; dwait=0 and queues empty after release.
